// File: rtl/lockin_pkg.sv
// rtl/lockin_pkg.sv - shared constants and types for the lock-in rectangular-to-polar CORDIC
package lockin_pkg;

    localparam int GUARD_BITS     = 2;
    localparam int MAX_ITERATIONS = 30;

    // atan(2^-i)/pi in Q1.31, i.e. 2^32 is one full turn
    localparam logic [31:0] ATAN_Q31 [0:MAX_ITERATIONS-1] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2F9, 32'h0000_517C,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A2F, 32'h0000_0517,
        32'h0000_028B, 32'h0000_0145, 32'h0000_00A2, 32'h0000_0051,
        32'h0000_0028, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0002, 32'h0000_0001
    };

    // Inverse CORDIC gain 0.6072529350 in Q1.31
    localparam logic [31:0] K_Q31 = 32'h4DBA_76D4;

    typedef struct packed {
        logic zero;
        logic y_zero;
        logic x_neg;
    } flags_t;

    function automatic logic [63:0] rescale_q31(input logic [31:0] v, input int bits);
        logic [63:0] w;
        w = {32'd0, v};
        if (bits >= 32) return w << (bits - 32);
        return (w + (64'd1 << (31 - bits))) >> (32 - bits);
    endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// rtl/cordic_vec_stage.sv - one registered vectoring-mode CORDIC micro-rotation
module cordic_vec_stage
    import lockin_pkg::*;
#(
    parameter int STAGE      = 0,
    parameter int WIDTH      = 34,
    parameter int PHASE_BITS = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] i_x,
    input  logic signed [WIDTH-1:0] i_y,
    input  logic [PHASE_BITS-1:0]   i_z,
    output logic signed [WIDTH-1:0] o_x,
    output logic signed [WIDTH-1:0] o_y,
    output logic [PHASE_BITS-1:0]   o_z
);

    localparam logic [63:0]           ATAN_FULL = rescale_q31(ATAN_Q31[STAGE], PHASE_BITS);
    localparam logic [PHASE_BITS-1:0] ATAN      = ATAN_FULL[PHASE_BITS-1:0];

    logic signed [WIDTH-1:0] w_xs;
    logic signed [WIDTH-1:0] w_ys;
    logic                    w_y_pos;

    assign w_xs    = i_x >>> STAGE;
    assign w_ys    = i_y >>> STAGE;
    assign w_y_pos = ~i_y[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_x <= '0;
            o_y <= '0;
            o_z <= '0;
        end else if (w_y_pos) begin
            o_x <= i_x + w_ys;
            o_y <= i_y - w_xs;
            o_z <= i_z + ATAN;
        end else begin
            o_x <= i_x - w_ys;
            o_y <= i_y + w_xs;
            o_z <= i_z - ATAN;
        end
    end

endmodule

// File: rtl/lockin_rect_to_polar.sv
// rtl/lockin_rect_to_polar.sv - pipelined CORDIC converting lock-in X/Y to magnitude and phase
module lockin_rect_to_polar
    import lockin_pkg::*;
#(
    parameter int INPUT_BITS  = 32,
    parameter int OUTPUT_BITS = 32,
    parameter int PHASE_BITS  = 32,
    parameter int ITERATIONS  = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INPUT_BITS-1:0]  X_in,
    input  logic [INPUT_BITS-1:0]  Y_in,
    input  logic                   in_valid,
    output logic [OUTPUT_BITS-1:0] R_out,
    output logic [PHASE_BITS-1:0]  P_out,
    output logic                   out_valid
);

    localparam int W    = INPUT_BITS + GUARD_BITS;
    localparam int PW   = W + OUTPUT_BITS + 1;
    localparam int FRAC = INPUT_BITS + OUTPUT_BITS - 2;
    localparam int LAST = ITERATIONS + 1;

    localparam logic [63:0]            K_FULL     = rescale_q31(K_Q31, OUTPUT_BITS);
    localparam logic [OUTPUT_BITS-1:0] K          = K_FULL[OUTPUT_BITS-1:0];
    localparam logic [PHASE_BITS-1:0]  P_MINUS_PI = {1'b1, {(PHASE_BITS-1){1'b0}}};
    localparam logic [OUTPUT_BITS-1:0] R_MAX      = {1'b0, {(OUTPUT_BITS-1){1'b1}}};

    logic signed [W-1:0]      w_xe, w_ye;
    logic signed [W-1:0]      r_x0, r_y0;
    logic [PHASE_BITS-1:0]    r_z0;
    flags_t                   w_flg;
    logic signed [W-1:0]      w_x [0:ITERATIONS];
    logic signed [W-1:0]      w_y [0:ITERATIONS];
    logic [PHASE_BITS-1:0]    w_z [0:ITERATIONS];
    logic                     r_vld [0:LAST];
    flags_t                   r_flg [0:LAST];
    logic signed [PW-1:0]     w_xg, w_kg;
    logic signed [PW-1:0]     r_prod;
    logic [PHASE_BITS-1:0]    r_zg;
    logic [OUTPUT_BITS-1:0]   w_r_sat;
    logic                     w_unused;

    assign w_xe         = {{GUARD_BITS{X_in[INPUT_BITS-1]}}, X_in};
    assign w_ye         = {{GUARD_BITS{Y_in[INPUT_BITS-1]}}, Y_in};
    assign w_flg.zero   = (X_in == '0) && (Y_in == '0);
    assign w_flg.y_zero = (Y_in == '0);
    assign w_flg.x_neg  = X_in[INPUT_BITS-1];

    // Fold the left half-plane onto the right so the micro-rotations always converge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x0 <= '0;
            r_y0 <= '0;
            r_z0 <= '0;
        end else if (w_flg.x_neg) begin
            r_x0 <= -w_xe;
            r_y0 <= -w_ye;
            r_z0 <= P_MINUS_PI;
        end else begin
            r_x0 <= w_xe;
            r_y0 <= w_ye;
            r_z0 <= '0;
        end
    end

    assign w_x[0] = r_x0;
    assign w_y[0] = r_y0;
    assign w_z[0] = r_z0;

    for (genvar i = 0; i < ITERATIONS; i++) begin : g_stage
        cordic_vec_stage #(
            .STAGE      (i),
            .WIDTH      (W),
            .PHASE_BITS (PHASE_BITS)
        ) u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .i_x   (w_x[i]),
            .i_y   (w_y[i]),
            .i_z   (w_z[i]),
            .o_x   (w_x[i+1]),
            .o_y   (w_y[i+1]),
            .o_z   (w_z[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LAST; k++) begin
                r_vld[k] <= 1'b0;
                r_flg[k] <= '0;
            end
        end else begin
            r_vld[0] <= in_valid;
            r_flg[0] <= w_flg;
            for (int k = 1; k <= LAST; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_flg[k] <= r_flg[k-1];
            end
        end
    end

    assign w_xg = {{(PW-W){w_x[ITERATIONS][W-1]}}, w_x[ITERATIONS]};
    assign w_kg = {{(PW-OUTPUT_BITS){1'b0}}, K};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_zg   <= '0;
        end else begin
            r_prod <= w_xg * w_kg;
            r_zg   <= w_z[ITERATIONS];
        end
    end

    // Product carries FRAC fractional bits; anything at or above 2^FRAC is >= 1.0
    always_comb begin
        w_r_sat = '0;
        if (r_prod[PW-1])
            w_r_sat = '0;
        else if (|r_prod[PW-2:FRAC])
            w_r_sat = R_MAX;
        else
            w_r_sat = {1'b0, r_prod[FRAC-1:INPUT_BITS-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R_out     <= '0;
            P_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= r_vld[LAST];
            if (r_vld[LAST]) begin
                if (r_flg[LAST].zero) begin
                    R_out <= '0;
                    P_out <= '0;
                end else begin
                    R_out <= w_r_sat;
                    P_out <= r_flg[LAST].y_zero ? (r_flg[LAST].x_neg ? P_MINUS_PI : '0) : r_zg;
                end
            end
        end
    end

    assign w_unused = ^{r_prod[INPUT_BITS-2:0], w_y[ITERATIONS]};

endmodule
